// File: rtl/botseidon_enc_pkg.sv
// Shared encoder definitions: command word format, window length defaults,
// quadrature state encoding and the command sign-convert/clamp helper.
package botseidon_enc_pkg;

  localparam int ENC_OFFSET        = 4092;     // 4 x 1023, zero-speed command
  localparam int DEF_WINDOW_CYCLES = 50_001;   // receiver measurement window
  localparam int DEF_MAX_EDGES     = 12_500;   // keeps >= 4 clk between edges

  // State values are chosen so that the state bits read directly as {A,B}.
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q10 = 2'b10,
    Q11 = 2'b11,
    Q01 = 2'b01
  } quad_state_t;

  typedef struct packed {
    logic signed [31:0] edges;
    logic               sat;
  } clamp_t;

  // Remove the offset (32-bit wrap) and clamp to +/- max_edges.
  function automatic clamp_t clamp_cmd(input logic        [31:0] cmd,
                                       input logic        [31:0] offset,
                                       input logic signed [31:0] max_edges);
    logic signed [31:0] raw;
    clamp_t             res;
    raw = $signed(cmd - offset);
    if (raw > max_edges) begin
      res.edges = max_edges;
      res.sat   = 1'b1;
    end else if (raw < -max_edges) begin
      res.edges = -max_edges;
      res.sat   = 1'b1;
    end else begin
      res.edges = raw;
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/quad_encoder_gen_quad_step.sv
// Two-bit Gray quadrature state machine. One step advances the A/B pair by
// one position, forward 00->10->11->01->00 or the reverse of that order.
module quad_step (
  input  logic clk,
  input  logic reset_n,
  input  logic step,
  input  logic dir,
  output logic A,
  output logic B
);
  import botseidon_enc_pkg::*;

  quad_state_t state;
  quad_state_t state_next;

  // Next quadrature state: dir=1 walks forward, dir=0 walks backward.
  always_comb begin
    state_next = state;
    if (step) begin
      case (state)
        Q00:     state_next = dir ? Q10 : Q01;
        Q10:     state_next = dir ? Q11 : Q00;
        Q11:     state_next = dir ? Q01 : Q10;
        Q01:     state_next = dir ? Q00 : Q11;
        default: state_next = Q00;
      endcase
    end
  end

  // State register; its bits are the A/B outputs, so they never glitch.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= Q00;
    else          state <= state_next;
  end

  assign A = state[1];
  assign B = state[0];

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator. A speed command (edges per window, offset
// encoded) is latched at each window wrap and a DDA phase accumulator spreads
// that many A/B edges evenly across the window.
module quad_encoder_gen #(
  parameter int WINDOW_CYCLES = botseidon_enc_pkg::DEF_WINDOW_CYCLES,
  parameter int ENC_OFFSET    = botseidon_enc_pkg::ENC_OFFSET,
  parameter int MAX_EDGES     = botseidon_enc_pkg::DEF_MAX_EDGES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [31:0] cmd,
  input  logic        cmd_valid,
  output logic        A,
  output logic        B,
  output logic        window_start,
  output logic [31:0] position,
  output logic        sat
);
  import botseidon_enc_pkg::*;

  localparam logic        [31:0] WIN   = 32'(WINDOW_CYCLES);
  localparam logic        [31:0] LAST  = 32'(WINDOW_CYCLES - 1);
  localparam logic        [31:0] OFFS  = 32'(ENC_OFFSET);
  localparam logic signed [31:0] MAXE  = 32'(MAX_EDGES);

  logic        [31:0] win_cnt;
  logic        [31:0] pend_cmd;
  logic signed [31:0] edges;
  logic        [31:0] acc;
  logic        [31:0] acc_next;
  logic        [31:0] mag;
  logic               wrap;
  clamp_t             clamp_p0;
  logic               step_p0;
  logic               dir_p0;

  assign wrap = (win_cnt == LAST);

  // A strobe on the wrap cycle itself bypasses the pending register.
  assign clamp_p0 = clamp_cmd(cmd_valid ? cmd : pend_cmd, OFFS, MAXE);

  assign mag      = edges[31] ? $unsigned(-edges) : $unsigned(edges);
  assign acc_next = acc + mag;

  // Stage p0: step decision from the accumulator; A/B and position follow
  // one cycle later.
  assign step_p0 = en && (acc_next >= WIN);
  assign dir_p0  = ~edges[31];

  // Free-running window counter and registered start-of-window pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      win_cnt      <= '0;
      window_start <= 1'b0;
    end else begin
      win_cnt      <= wrap ? '0 : win_cnt + 32'd1;
      window_start <= wrap;
    end
  end

  // Latest command strobe wins.
  always_ff @(posedge clk) begin
    if (!reset_n)       pend_cmd <= OFFS;
    else if (cmd_valid) pend_cmd <= cmd;
  end

  // Apply the clamped command as the new edge count at each window wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edges <= '0;
      sat   <= 1'b0;
    end else if (wrap) begin
      edges <= clamp_p0.edges;
      sat   <= clamp_p0.sat;
    end
  end

  // DDA phase accumulator, cleared at every wrap and while disabled.
  always_ff @(posedge clk) begin
    if (!reset_n)         acc <= '0;
    else if (wrap || !en) acc <= '0;
    else if (step_p0)     acc <= acc_next - WIN;
    else                  acc <= acc_next;
  end

  // Stage p1: net step count, updated on the same edge as A/B.
  always_ff @(posedge clk) begin
    if (!reset_n)     position <= '0;
    else if (step_p0) position <= dir_p0 ? position + 32'd1 : position - 32'd1;
  end

  quad_step u_quad_step (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (step_p0),
    .dir     (dir_p0),
    .A       (A),
    .B       (B)
  );

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen with a short window. Per-window expectations go
// into a queue when the command is driven; a monitor pops and compares them
// at each window_start.
module tb_quad_encoder_gen;

  localparam int W   = 401;
  localparam int MAXE = 100;
  localparam int OFF = 4092;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic        A, B;
  logic        window_start;
  logic [31:0] position;
  logic        sat;

  quad_encoder_gen #(
    .WINDOW_CYCLES (W),
    .ENC_OFFSET    (OFF),
    .MAX_EDGES     (MAXE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .A            (A),
    .B            (B),
    .window_start (window_start),
    .position     (position),
    .sat          (sat)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint got, input longint want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  typedef struct {
    int steps;
    int delta;
    bit sat;
    bit last;
  } exp_t;

  exp_t sbq[$];

  task automatic push(input int steps, input int delta, input bit s, input bit last);
    exp_t e;
    e.steps = steps;
    e.delta = delta;
    e.sat   = s;
    e.last  = last;
    sbq.push_back(e);
  endtask

  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Monitor state
  bit          mon_on = 1'b0;
  logic [1:0]  prev_ab = 2'b00;
  int          n_fwd = 0, n_rev = 0, n_bad = 0, win_trans = 0;
  int          gap = 1000, min_gap = 1000, win_cyc = 0, widx = 0;
  bit          last_on_ws = 1'b0, have_prev = 1'b0, cur_sat = 1'b0;
  logic [31:0] win_start_pos = '0;

  always @(negedge clk) begin
    if (mon_on) begin
      logic [1:0] ab;
      exp_t       e;
      ab = {A, B};
      gap++;
      win_cyc++;
      last_on_ws = 1'b0;
      if (ab != prev_ab) begin
        win_trans++;
        if (ab == fwd_next(prev_ab))      n_fwd++;
        else if (ab == rev_next(prev_ab)) n_rev++;
        else                              n_bad++;
        if (gap < min_gap) min_gap = gap;
        gap = 0;
        last_on_ws = window_start;
      end
      prev_ab = ab;
      if (window_start) begin
        check($sformatf("w%0d_have_exp", widx), sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check($sformatf("w%0d_fwd", widx), n_fwd, (e.delta >= 0) ? e.steps : 0);
          check($sformatf("w%0d_rev", widx), n_rev, (e.delta < 0) ? e.steps : 0);
          check($sformatf("w%0d_gray", widx), n_bad, 0);
          check($sformatf("w%0d_pos_delta", widx), int'($signed(position - win_start_pos)), e.delta);
          check($sformatf("w%0d_sat", widx), cur_sat, e.sat);
          if (e.last && e.steps > 0)
            check($sformatf("w%0d_last_edge", widx), last_on_ws, 1);
          if (e.sat)
            check($sformatf("w%0d_min_gap_ge4", widx), min_gap >= 4, 1);
        end
        if (have_prev) check($sformatf("w%0d_period", widx), win_cyc, W);
        have_prev     = 1'b1;
        win_cyc       = 0;
        n_fwd         = 0;
        n_rev         = 0;
        n_bad         = 0;
        win_trans     = 0;
        min_gap       = 1000;
        win_start_pos = position;
        cur_sat       = sat;
        widx++;
      end
    end
  end

  task automatic wait_ws();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!window_start && n < 2 * W);
    if (!window_start) begin
      check("ws_timeout", n, W);
      finish_tb();
    end
  endtask

  // Called at a negedge; the strobe is sampled by the following posedge.
  task automatic pulse_cmd(input logic [31:0] v);
    cmd       = v;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int n;
    reset_n   = 1'b0;
    en        = 1'b0;
    cmd       = '0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    check("rst_pos", position, 0);
    check("rst_ws", window_start, 0);
    check("rst_sat", sat, 0);

    en      = 1'b1;
    reset_n = 1'b1;
    mon_on  = 1'b1;

    // Windows 0..2: idle command, no edges.
    push(0, 0, 0, 1);
    push(0, 0, 0, 1);
    wait_ws();
    push(0, 0, 0, 1);
    wait_ws();
    // Window 3: +60 forward.
    repeat (10) @(negedge clk);
    pulse_cmd(OFF + 60);
    push(60, 60, 0, 1);
    wait_ws();
    // Window 4: 37 reverse.
    repeat (10) @(negedge clk);
    pulse_cmd(OFF - 37);
    push(37, -37, 0, 1);
    wait_ws();
    // Window 5: +500 clamps to +100, direction reverses at the boundary.
    repeat (10) @(negedge clk);
    pulse_cmd(OFF + 500);
    push(MAXE, MAXE, 1, 1);
    wait_ws();
    // Window 6: strobes of +10, +50, then +80 on the wrap cycle.
    repeat (5) @(negedge clk);
    pulse_cmd(OFF + 10);
    repeat (150) @(negedge clk);
    pulse_cmd(OFF + 50);
    repeat (W - 1 - 155) @(negedge clk);
    pulse_cmd(OFF + 80);
    push(80, 80, 0, 1);
    wait_ws();
    // Window 7: +100, but en drops after 30 steps.
    repeat (10) @(negedge clk);
    pulse_cmd(OFF + 100);
    push(30, 30, 0, 0);
    wait_ws();
    g = 0;
    do begin
      @(posedge clk);
      #1;
      g++;
    end while (win_trans < 30 && g < W);
    check("endrop_reached_30", win_trans >= 30, 1);
    en = 1'b0;
    // Window 8: pending still +100, en restored at window start.
    push(100, 100, 0, 1);
    wait_ws();
    en = 1'b1;
    repeat (10) @(negedge clk);
    // Window 9: large negative command clamps to -100.
    pulse_cmd(OFF - 20000);
    push(MAXE, -MAXE, 1, 1);
    wait_ws();
    // Window 10: burst interrupted by reset.
    repeat (10) @(negedge clk);
    pulse_cmd(OFF + 100);
    wait_ws();
    repeat (200) @(negedge clk);
    check("burst_pos_nonzero", position != 0, 1);
    mon_on  = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_A", A, 0);
    check("midrst_B", B, 0);
    check("midrst_pos", position, 0);
    check("midrst_ws", window_start, 0);
    check("midrst_sat", sat, 0);
    reset_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!window_start && n < 2 * W);
    check("postrst_ws_delay", n, W);
    check("postrst_pos", position, 0);
    check("postrst_AB", {A, B}, 0);
    check("sb_drained", sbq.size(), 0);
    finish_tb();
  end

endmodule

// File: doc/quad_encoder_gen.md
Name: quad_encoder_gen

Overview:
Quadrature encoder emulator: converts an offset-encoded speed command (edges per measurement window) into A/B quadrature waveforms. Uses the same word format and window length as the minibot encoder receiver. Used for motor-loop bring-up without wheels and for closed-loop HIL checks of the receiver path. Edges are spread evenly across each window by a DDA phase accumulator.

Parameters:
WINDOW_CYCLES, 50_001, window period in clk cycles; matches the receiver window.
ENC_OFFSET, 4092, command zero point (4 × 1023); edges = cmd − ENC_OFFSET.
MAX_EDGES, 12_500, clamp on |edges| per window; guarantees ≥4 clk between edges.

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
en  input  1  generation enable
cmd  input  32  offset-encoded edges-per-window command (unsigned)
cmd_valid  input  1  cmd strobe; any cycle, latest wins
A  output  1  quadrature channel A (registered)
B  output  1  quadrature channel B (registered)
window_start  output  1  one-cycle pulse on first cycle of each window
position  output  32  signed net step count (forward +1, reverse −1)
sat  output  1  active command was clamped to ±MAX_EDGES

Behaviour:
- Reset (reset_n=0 at posedge clk): A=0, B=0, position=0, window_start=0, sat=0, window counter=0, accumulator=0, active edges=0, pending cmd=ENC_OFFSET.
- Window counter counts 0..WINDOW_CYCLES−1, then wraps. It runs regardless of en.
- cmd capture: on cmd_valid, pending <= cmd. No backpressure.
- Command apply: on the cycle the counter wraps to 0:
  - active edges <= signed(pending − ENC_OFFSET), 32-bit two's complement, clamped to [−MAX_EDGES, +MAX_EDGES].
  - If cmd_valid is high on that same cycle, that cmd is applied directly (bypass).
  - sat <= 1 if the clamp engaged, else 0.
  - accumulator <= 0.
  - window_start = 1 on the following cycle (counter==0), 0 otherwise.
- DDA, each cycle with en=1: acc_next = acc + |edges|. If acc_next ≥ WINDOW_CYCLES, then acc <= acc_next − WINDOW_CYCLES and one step is issued. Otherwise acc <= acc_next.
- At most one step per cycle. Exactly |edges| steps per full enabled window; the last step falls on the window's final cycle.
- Step direction: edges>0 forward, edges<0 reverse, edges=0 no steps.
  - Forward (A,B) sequence: 00→10→11→01→00, so the receiver counts up.
  - Reverse is the inverse sequence.
  - Exactly one of A/B toggles per step (Gray), and the change is visible on A/B the cycle after the step decision.
- position: +1 per forward step, −1 per reverse step, wraps modulo 2^32.
- en=0: no steps, A/B and position hold, acc forced to 0. Command capture and apply continue. en rising mid-window resumes with acc=0, so that window yields fewer than |edges| steps.
- Direction reversal at a window boundary: next step goes backward from the current A/B state. No glitch and no skipped state.
- Reset mid-window: all state returns to reset values on the next edge. The new window starts at counter=0.

Decomposition:
- Package botseidon_enc_pkg holds:
  - ENC_OFFSET
  - default WINDOW_CYCLES
  - typedef enum logic[1:0] quad_state_t {Q00, Q10, Q11, Q01}
  - function to sign-convert and clamp a command
- One sub-module, quad_step: 2-bit Gray state machine with inputs step and dir, registered outputs A and B. Same clock and reset.
- Window counter, DDA and position stay in quad_encoder_gen.

Test Plan:
- Reset, en=1, no cmd: over 3 windows A=B=0, position=0, sat=0, window_start pulses every 50_001 cycles.
- cmd=4092+100, en=1: next full window gives exactly 100 A/B transitions with sequence 00→10→11→01, position +100, and the last edge on the window's final cycle. Feeding A/B to the encoder receiver reads back 4192.
- cmd=4092−37: next window gives 37 reverse steps (00→01→11→10) and position −37. Receiver reads back 4055.
- cmd=4092+20_000: sat=1 and exactly 12_500 steps in the window; minimum spacing between A/B changes ≥4 clk.
- cmd_valid pulses of 4092+10 then 4092+50 in the same window, plus 4092+80 on the wrap cycle: only 80 is applied in the next window.
- en dropped mid-window after 30 of 100 steps: A/B freeze. Next window with en=1 gives 100 steps. reset_n low mid-burst: A=B=0 and position=0 the next cycle.
